// File: rtl/clock_alarm_pkg.sv
`timescale 1ns/1ps
// Shared widths, limits, FSM state type and alarm record for the multi-alarm clock.
package clock_alarm_pkg;

  localparam int HR_W   = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;
  localparam int MAX_HR = 23;
  localparam int MAX_MS = 59;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } alarm_state_t;

  typedef struct packed {
    logic [HR_W-1:0]  hr;
    logic [MIN_W-1:0] min;
    logic             en;
  } alarm_t;

  function automatic logic valid_hm(input logic [HR_W-1:0] h, input logic [MIN_W-1:0] m);
    return (h <= HR_W'(MAX_HR)) && (m <= MIN_W'(MAX_MS));
  endfunction

  function automatic logic valid_time(input logic [HR_W-1:0] h, input logic [MIN_W-1:0] m,
                                      input logic [SEC_W-1:0] s);
    return valid_hm(h, m) && (s <= SEC_W'(MAX_MS));
  endfunction

  // hh:mm + delta minutes, wrapping at midnight; delta is at most 59 so one carry suffices.
  function automatic logic [HR_W+MIN_W-1:0] add_minutes(input logic [HR_W-1:0]  h,
                                                        input logic [MIN_W-1:0] m,
                                                        input logic [MIN_W-1:0] delta);
    logic [MIN_W:0]   m_sum;
    logic [HR_W-1:0]  h_out;
    logic [MIN_W-1:0] m_out;
    m_sum = {1'b0, m} + {1'b0, delta};
    h_out = h;
    m_out = m_sum[MIN_W-1:0];
    if (m_sum > (MIN_W+1)'(MAX_MS)) begin
      m_out = MIN_W'(m_sum - (MIN_W+1)'(MAX_MS + 1));
      h_out = (h == HR_W'(MAX_HR)) ? '0 : h + 1'b1;
    end
    return {h_out, m_out};
  endfunction

endpackage

// File: rtl/time_of_day_counter.sv
`timescale 1ns/1ps
// Prescaled hh:mm:ss counter with validated load; exposes the next-state time so the
// alarm logic can act on the same edge that updates the display.
module time_of_day_counter
  import clock_alarm_pkg::*;
#(
  parameter int CLK_PER_SEC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [HR_W-1:0]  set_hr,
  input  logic [MIN_W-1:0] set_min,
  input  logic [SEC_W-1:0] set_sec,
  output logic [HR_W-1:0]  hr,
  output logic [MIN_W-1:0] min,
  output logic [SEC_W-1:0] sec,
  output logic             tick,
  output logic [HR_W-1:0]  nxt_hr,
  output logic [MIN_W-1:0] nxt_min,
  output logic [SEC_W-1:0] nxt_sec,
  output logic             nxt_tick,
  output logic             load_ok
);

  localparam int PS_W = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_PER_SEC - 1);

  logic [PS_W-1:0] presc;
  logic [PS_W-1:0] nxt_presc;
  logic            wrap;

  always_comb begin
    wrap      = (presc == PS_LAST);
    load_ok   = set_en && valid_time(set_hr, set_min, set_sec);
    nxt_hr    = hr;
    nxt_min   = min;
    nxt_sec   = sec;
    nxt_tick  = 1'b0;
    nxt_presc = wrap ? '0 : presc + 1'b1;
    if (load_ok) begin
      nxt_hr    = set_hr;
      nxt_min   = set_min;
      nxt_sec   = set_sec;
      nxt_presc = '0;
    end else if (wrap) begin
      nxt_tick = 1'b1;
      if (sec == SEC_W'(MAX_MS)) begin
        nxt_sec = '0;
        if (min == MIN_W'(MAX_MS)) begin
          nxt_min = '0;
          nxt_hr  = (hr == HR_W'(MAX_HR)) ? '0 : hr + 1'b1;
        end else begin
          nxt_min = min + 1'b1;
        end
      end else begin
        nxt_sec = sec + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
      hr    <= '0;
      min   <= '0;
      sec   <= '0;
      tick  <= 1'b0;
    end else begin
      presc <= nxt_presc;
      hr    <= nxt_hr;
      min   <= nxt_min;
      sec   <= nxt_sec;
      tick  <= nxt_tick;
    end
  end

endmodule

// File: rtl/fpga_multi_alarm_clock.sv
`timescale 1ns/1ps
// Multi-alarm 24-hour clock: alarm register bank, lowest-index match priority,
// snooze target and the IDLE/RING/SNOOZE buzzer FSM.
module fpga_multi_alarm_clock
  import clock_alarm_pkg::*;
#(
  parameter int CLK_PER_SEC = 1,
  parameter int NUM_ALARMS  = 4,
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_MIN  = 5,
  localparam int IDX_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [HR_W-1:0]  set_hr,
  input  logic [MIN_W-1:0] set_min,
  input  logic [SEC_W-1:0] set_sec,
  input  logic             alarm_wr,
  input  logic [IDX_W-1:0] alarm_idx,
  input  logic [HR_W-1:0]  alarm_wr_hr,
  input  logic [MIN_W-1:0] alarm_wr_min,
  input  logic             alarm_wr_en,
  input  logic             snooze,
  input  logic             stop,
  output logic [HR_W-1:0]  hr,
  output logic [MIN_W-1:0] min,
  output logic [SEC_W-1:0] sec,
  output logic             tick,
  output logic             buzzer,
  output logic [IDX_W-1:0] active_idx,
  output logic             snoozing
);

  localparam int RC_W = $clog2(RING_SECS + 1);
  localparam logic [RC_W-1:0] RING_LOAD = RC_W'(RING_SECS);

  logic [HR_W-1:0]  nxt_hr;
  logic [MIN_W-1:0] nxt_min;
  logic [SEC_W-1:0] nxt_sec;
  logic             nxt_tick;
  logic             load_ok;

  alarm_t           alarms [NUM_ALARMS];
  alarm_state_t     state;
  logic [RC_W-1:0]  ring_cnt;
  logic [HR_W-1:0]  tgt_hr;
  logic [MIN_W-1:0] tgt_min;
  logic [HR_W-1:0]  snz_hr;
  logic [MIN_W-1:0] snz_min;
  logic             on_minute;
  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic             tgt_hit;
  logic             wr_ok;

  time_of_day_counter #(
    .CLK_PER_SEC (CLK_PER_SEC)
  ) u_tod (
    .clk      (clk),
    .rst      (rst),
    .set_en   (set_en),
    .set_hr   (set_hr),
    .set_min  (set_min),
    .set_sec  (set_sec),
    .hr       (hr),
    .min      (min),
    .sec      (sec),
    .tick     (tick),
    .nxt_hr   (nxt_hr),
    .nxt_min  (nxt_min),
    .nxt_sec  (nxt_sec),
    .nxt_tick (nxt_tick),
    .load_ok  (load_ok)
  );

  // Matches look at the time the counter is about to show, so the buzzer rises with hh:mm:00.
  always_comb begin
    on_minute = nxt_tick && (nxt_sec == '0);
    hit       = 1'b0;
    hit_idx   = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (on_minute && alarms[i].en && (alarms[i].hr == nxt_hr) && (alarms[i].min == nxt_min)) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
    tgt_hit            = on_minute && (nxt_hr == tgt_hr) && (nxt_min == tgt_min);
    {snz_hr, snz_min}  = add_minutes(hr, min, MIN_W'(SNOOZE_MIN));
    wr_ok              = alarm_wr && valid_hm(alarm_wr_hr, alarm_wr_min);
  end

  // Out-of-range indices simply match no channel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        alarms[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (wr_ok && (alarm_idx == IDX_W'(i))) begin
          alarms[i] <= '{hr: alarm_wr_hr, min: alarm_wr_min, en: alarm_wr_en};
        end
      end
    end
  end

  // The snooze target is only consulted in SNOOZE, which is always entered through this load.
  always_ff @(posedge clk) begin
    if (!load_ok && (state == RING) && !stop && snooze) begin
      tgt_hr  <= snz_hr;
      tgt_min <= snz_min;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      buzzer     <= 1'b0;
      snoozing   <= 1'b0;
      active_idx <= '0;
      ring_cnt   <= '0;
    end else if (load_ok) begin
      state    <= IDLE;
      buzzer   <= 1'b0;
      snoozing <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            state      <= RING;
            buzzer     <= 1'b1;
            active_idx <= hit_idx;
            ring_cnt   <= RING_LOAD;
          end
        end
        RING: begin
          if (stop) begin
            state  <= IDLE;
            buzzer <= 1'b0;
          end else if (snooze) begin
            state    <= SNOOZE;
            buzzer   <= 1'b0;
            snoozing <= 1'b1;
          end else if (nxt_tick) begin
            if (ring_cnt == RC_W'(1)) begin
              state  <= IDLE;
              buzzer <= 1'b0;
            end else begin
              ring_cnt <= ring_cnt - 1'b1;
            end
          end
        end
        SNOOZE: begin
          if (stop) begin
            state    <= IDLE;
            snoozing <= 1'b0;
          end else if (hit || tgt_hit) begin
            state    <= RING;
            buzzer   <= 1'b1;
            snoozing <= 1'b0;
            ring_cnt <= RING_LOAD;
            if (hit) begin
              active_idx <= hit_idx;
            end
          end
        end
        default: begin
          state    <= IDLE;
          buzzer   <= 1'b0;
          snoozing <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_multi_alarm_clock.sv
`timescale 1ns/1ps
// Bench for fpga_multi_alarm_clock: vector table, directed alarm/snooze sequences and a
// randomized run against a seconds-of-day reference model.
module tb_fpga_multi_alarm_clock;

  localparam int NA = 5;
  localparam int RS = 60;
  localparam int SM = 5;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rst4 = 1'b0;
  logic          set_en = 1'b0;
  logic [4:0]    set_hr = '0;
  logic [5:0]    set_min = '0;
  logic [5:0]    set_sec = '0;
  logic          alarm_wr = 1'b0;
  logic [IW-1:0] alarm_idx = '0;
  logic [4:0]    alarm_wr_hr = '0;
  logic [5:0]    alarm_wr_min = '0;
  logic          alarm_wr_en = 1'b0;
  logic          snooze = 1'b0;
  logic          stop = 1'b0;

  logic [4:0]    hr, hr4;
  logic [5:0]    min, min4, sec, sec4;
  logic          tick, tick4, buzzer, buzzer4, snoozing, snoozing4;
  logic [IW-1:0] active_idx, active_idx4;

  fpga_multi_alarm_clock #(.CLK_PER_SEC(1), .NUM_ALARMS(NA), .RING_SECS(RS), .SNOOZE_MIN(SM)) dut (
    .clk(clk), .rst(rst), .set_en(set_en), .set_hr(set_hr), .set_min(set_min), .set_sec(set_sec),
    .alarm_wr(alarm_wr), .alarm_idx(alarm_idx), .alarm_wr_hr(alarm_wr_hr),
    .alarm_wr_min(alarm_wr_min), .alarm_wr_en(alarm_wr_en), .snooze(snooze), .stop(stop),
    .hr(hr), .min(min), .sec(sec), .tick(tick), .buzzer(buzzer),
    .active_idx(active_idx), .snoozing(snoozing));

  fpga_multi_alarm_clock #(.CLK_PER_SEC(4), .NUM_ALARMS(NA), .RING_SECS(RS), .SNOOZE_MIN(SM)) dut4 (
    .clk(clk), .rst(rst4), .set_en(set_en), .set_hr(set_hr), .set_min(set_min), .set_sec(set_sec),
    .alarm_wr(alarm_wr), .alarm_idx(alarm_idx), .alarm_wr_hr(alarm_wr_hr),
    .alarm_wr_min(alarm_wr_min), .alarm_wr_en(alarm_wr_en), .snooze(snooze), .stop(stop),
    .hr(hr4), .min(min4), .sec(sec4), .tick(tick4), .buzzer(buzzer4),
    .active_idx(active_idx4), .snoozing(snoozing4));

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: time as seconds of day, mode 0=idle 1=ring 2=snooze, target as minute of day.
  int m_tod = 0, m_ps = 0, m_mode = 0, m_left = 0, m_tgt = 0, m_idx = 0;
  bit m_tick = 0;
  int m_ahr [NA];
  int m_amin[NA];
  bit m_aen [NA];

  typedef struct {
    bit se;
    int h, m, s;
    int eh, em, es;
    bit et;
  } vec_t;
  vec_t tv[9];

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int tod_a();
    return int'(hr) * 3600 + int'(min) * 60 + int'(sec);
  endfunction

  function automatic int tod_b();
    return int'(hr4) * 3600 + int'(min4) * 60 + int'(sec4);
  endfunction

  task automatic model_edge();
    bit ld, ntick, found;
    int ntod, nps, fi;
    ld = set_en && set_hr <= 23 && set_min <= 59 && set_sec <= 59;
    if (ld) begin
      ntod = int'(set_hr) * 3600 + int'(set_min) * 60 + int'(set_sec); ntick = 0; nps = 0;
    end else if (m_ps == 0) begin
      ntod = (m_tod + 1) % 86400; ntick = 1; nps = 0;
    end else begin
      ntod = m_tod; ntick = 0; nps = m_ps + 1;
    end
    found = 0; fi = 0;
    if (ntick && ntod % 60 == 0)
      for (int i = 0; i < NA; i++)
        if (!found && m_aen[i] && m_ahr[i] * 60 + m_amin[i] == ntod / 60) begin
          found = 1; fi = i;
        end
    if (ld) m_mode = 0;
    else case (m_mode)
      0: if (found) begin m_mode = 1; m_idx = fi; m_left = RS; end
      1: if (stop) m_mode = 0;
         else if (snooze) begin m_mode = 2; m_tgt = (m_tod / 60 + SM) % 1440; end
         else if (ntick) begin m_left--; if (m_left == 0) m_mode = 0; end
      default: if (stop) m_mode = 0;
         else if (found) begin m_mode = 1; m_idx = fi; m_left = RS; end
         else if (ntick && ntod % 60 == 0 && ntod / 60 == m_tgt) begin m_mode = 1; m_left = RS; end
    endcase
    if (alarm_wr && int'(alarm_idx) < NA && alarm_wr_hr <= 23 && alarm_wr_min <= 59) begin
      m_ahr[alarm_idx] = alarm_wr_hr; m_amin[alarm_idx] = alarm_wr_min; m_aen[alarm_idx] = alarm_wr_en;
    end
    m_tod = ntod; m_tick = ntick; m_ps = nps;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("model_time", tod_a(), m_tod);
    check("model_tick", tick, m_tick);
    check("model_buzzer", buzzer, m_mode == 1);
    check("model_snoozing", snoozing, m_mode == 2);
    check("model_active_idx", active_idx, m_idx);
  endtask

  task automatic set_time(input int h, input int m, input int s);
    set_en = 1'b1; set_hr = 5'(h); set_min = 6'(m); set_sec = 6'(s);
    cycle();
    set_en = 1'b0;
  endtask

  task automatic write_alarm(input int i, input int h, input int m, input bit e);
    alarm_wr = 1'b1; alarm_idx = IW'(i); alarm_wr_hr = 5'(h); alarm_wr_min = 6'(m); alarm_wr_en = e;
    cycle();
    alarm_wr = 1'b0;
  endtask

  task automatic wait_buzzer(input string name, input int bound);
    int n = 0;
    while (buzzer !== 1'b1 && n < bound) begin cycle(); n++; end
    check(name, buzzer, 1);
  endtask

  task automatic wait_sec(input string name, input int s, input int bound);
    int n = 0;
    while (int'(sec) != s && n < bound) begin cycle(); n++; end
    check(name, sec, s);
  endtask

  task automatic pulse_stop();
    stop = 1'b1; cycle(); stop = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 2000000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < NA; i++) begin m_ahr[i] = 0; m_amin[i] = 0; m_aen[i] = 0; end
    tv[0] = '{1, 23, 59, 58, 23, 59, 58, 0};
    tv[1] = '{0,  0,  0,  0, 23, 59, 59, 1};
    tv[2] = '{0,  0,  0,  0,  0,  0,  0, 1};
    tv[3] = '{0,  0,  0,  0,  0,  0,  1, 1};
    tv[4] = '{1, 24,  0,  0,  0,  0,  2, 1};
    tv[5] = '{1,  1, 60,  0,  0,  0,  3, 1};
    tv[6] = '{1,  1,  0, 60,  0,  0,  4, 1};
    tv[7] = '{1, 12, 34, 56, 12, 34, 56, 0};
    tv[8] = '{0,  0,  0,  0, 12, 34, 57, 1};

    #20;
    check("rst_time", tod_a(), 0);
    check("rst_tick", tick, 0);
    check("rst_buzzer", buzzer, 0);
    check("rst_snoozing", snoozing, 0);
    check("rst_active_idx", active_idx, 0);
    check("rst_b_time", tod_b(), 0);
    rst = 1'b1;
    cycle();
    check("first_edge_time", tod_a(), 1);
    check("first_edge_tick", tick, 1);

    for (int i = 0; i < 9; i++) begin
      set_en = tv[i].se; set_hr = 5'(tv[i].h); set_min = 6'(tv[i].m); set_sec = 6'(tv[i].s);
      cycle();
      check($sformatf("vec%0d_time", i), tod_a(), tv[i].eh * 3600 + tv[i].em * 60 + tv[i].es);
      check($sformatf("vec%0d_tick", i), tick, tv[i].et);
    end
    set_en = 1'b0;

    // Alarm 0 at 00:01 rings for exactly RS seconds.
    write_alarm(0, 0, 1, 1);
    set_time(0, 0, 55);
    wait_buzzer("ring_rise", 20);
    check("ring_rise_time", tod_a(), 60);
    check("ring_idx", active_idx, 0);
    n = 1;
    for (int k = 0; k < 100; k++) begin
      cycle();
      if (buzzer) n++;
      else break;
    end
    check("ring_len", n, RS);
    check("ring_fall_time", tod_a(), 120);

    // Snooze at 0:1:10 re-rings at 0:6:0.
    set_time(0, 0, 58);
    wait_buzzer("snz_ring", 10);
    wait_sec("snz_sec10", 10, 20);
    snooze = 1'b1; cycle(); snooze = 1'b0;
    check("snz_buzzer_off", buzzer, 0);
    check("snz_snoozing", snoozing, 1);
    wait_buzzer("snz_rering", 400);
    check("snz_rering_time", tod_a(), 360);
    check("snz_rering_idle_flag", snoozing, 0);
    pulse_stop();
    check("snz_stop", buzzer, 0);

    // Snooze target across midnight.
    write_alarm(0, 23, 58, 1);
    set_time(23, 57, 58);
    wait_buzzer("mid_ring", 10);
    check("mid_ring_time", tod_a(), 23 * 3600 + 58 * 60);
    wait_sec("mid_sec10", 10, 20);
    snooze = 1'b1; cycle(); snooze = 1'b0;
    wait_buzzer("mid_rering", 400);
    check("mid_rering_time", tod_a(), 180);
    pulse_stop();

    // Priority and rejected writes.
    write_alarm(0, 0, 2, 0);
    write_alarm(1, 0, 2, 1);
    write_alarm(2, 0, 2, 1);
    write_alarm(5, 0, 3, 1);
    write_alarm(1, 0, 60, 0);
    write_alarm(2, 24, 2, 0);
    set_time(0, 1, 58);
    wait_buzzer("prio_ring", 10);
    check("prio_time", tod_a(), 120);
    check("prio_idx", active_idx, 1);

    // stop and snooze together: stop wins.
    stop = 1'b1; snooze = 1'b1; cycle(); stop = 1'b0; snooze = 1'b0;
    check("stop_snz_buzzer", buzzer, 0);
    check("stop_snz_snoozing", snoozing, 0);

    // Load during ring returns to idle.
    set_time(0, 1, 59);
    wait_buzzer("load_ring", 5);
    set_time(12, 0, 0);
    check("load_ring_buzzer", buzzer, 0);
    check("load_ring_time", tod_a(), 12 * 3600);
    cycle();
    check("load_ring_next", tod_a(), 12 * 3600 + 1);

    // Disabling the ringing channel leaves the ring going.
    set_time(0, 1, 59);
    wait_buzzer("dis_ring", 5);
    write_alarm(1, 0, 2, 0);
    cycle();
    check("dis_still_ring", buzzer, 1);
    check("dis_idx", active_idx, 1);
    pulse_stop();

    // Randomized run against the model.
    for (int k = 0; k < 4000; k++) begin
      int r, cm;
      r = int'($urandom_range(0, 999));
      set_en  = (r < 4);
      set_hr  = 5'($urandom_range(0, 24));
      set_min = 6'($urandom_range(0, 60));
      set_sec = 6'($urandom_range(0, 60));
      alarm_wr  = ($urandom_range(0, 99) < 3);
      alarm_idx = 3'($urandom_range(0, 7));
      cm = (m_tod / 60 + int'($urandom_range(0, 4))) % 1440;
      alarm_wr_hr  = 5'(cm / 60);
      alarm_wr_min = ($urandom_range(0, 9) == 0) ? 6'(60) : 6'(cm % 60);
      alarm_wr_en  = ($urandom_range(0, 3) != 0);
      snooze = ($urandom_range(0, 99) < 3);
      stop   = ($urandom_range(0, 199) < 1);
      cycle();
    end
    set_en = 1'b0; alarm_wr = 1'b0; snooze = 1'b0; stop = 1'b0;

    // CLK_PER_SEC=4 instance.
    rst4 = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      cycle();
      check($sformatf("b_tick_c%0d", c), tick4, (c % 4) == 0);
      check($sformatf("b_sec_c%0d", c), sec4, c / 4);
    end
    cycle();
    cycle();
    set_time(1, 2, 3);
    check("b_load_time", tod_b(), 3723);
    check("b_load_tick", tick4, 0);
    for (int c = 1; c <= 4; c++) begin
      cycle();
      check($sformatf("b_post_tick_c%0d", c), tick4, c == 4);
      check($sformatf("b_post_sec_c%0d", c), sec4, (c == 4) ? 4 : 3);
    end

    // Asynchronous reset in the middle of a ring.
    write_alarm(0, 0, 1, 1);
    set_time(0, 0, 58);
    wait_buzzer("arst_ring", 5);
    #2;
    rst = 1'b0;
    #1;
    check("arst_buzzer", buzzer, 0);
    check("arst_time", tod_a(), 0);
    check("arst_idx", active_idx, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
